// File: rtl/ahb_burst_master.sv
// ahb_burst_master: turns one command (address, direction, size, beat count)
// into a complete AHB-Lite SINGLE / INCR4/8/16 / INCR transfer sequence with
// wait states, write-data back-pressure via BUSY, and ERROR handling.
// Build option: define AHB_MASTER_ERR_ABORT_EN to terminate a burst on ERROR;
// otherwise every beat completes and the error is reported sticky with done.
module ahb_burst_master #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 5
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_write,
  input  logic [2:0]        cmd_size,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              rdata_last,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] HADDR,
  output logic [DATA_W-1:0] HWDATA,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  input  logic              HREADY,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic [1:0]        HRESP
);

  localparam logic [2:0] SIZE_MAX = 3'($clog2(DATA_W / 8));
  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

`ifdef AHB_MASTER_ERR_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_LAST, S_ABORT} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [2:0]        r_size;
  logic [2:0]        r_burst;
  logic              r_write;
  logic [LEN_W-1:0]  r_left;    // beats whose address phase is still to be issued
  logic              r_first;   // next address phase is the NONSEQ beat
  logic              r_dphase;  // a data phase is in progress
  logic              r_err;     // sticky ERROR seen during this command

  logic [1:0]        w_htrans;
  logic [2:0]        w_burst;
  logic [ADDR_W-1:0] w_step;
  logic              w_resp_err;
  logic              w_err1;
  logic              w_abort;
  logic              w_issue;
  logic              w_accept;
  logic              w_capture;

  assign w_resp_err = |HRESP;
  // First cycle of the two-cycle ERROR response: HREADY is still low.
  assign w_err1     = r_dphase && w_resp_err && !HREADY;
  assign w_abort    = ABORT_EN && w_err1;
  assign w_issue    = !r_write || wdata_valid;
  // Acceptance is derived from the HTRANS the output process drives, so the
  // next-state and datapath logic see exactly what the bus sees.
  assign w_accept   = (r_state == S_ADDR) && HREADY && w_htrans[1];
  assign w_capture  = cmd_valid && (r_state == S_IDLE);
  assign w_step     = {{(ADDR_W-1){1'b0}}, 1'b1} << r_size;

  assign wdata_ready = w_accept && r_write;
  assign rdata       = HRDATA;
  assign HTRANS      = w_htrans;
  assign HADDR       = r_addr;
  assign HWDATA      = r_wdata;
  assign HSIZE       = r_size;
  assign HBURST      = r_burst;
  assign HWRITE      = r_write;

  // Map the requested beat count onto the AHB burst type.
  always_comb begin
    w_burst = 3'b001;
    if (int'(cmd_len) == 1)       w_burst = 3'b000;
    else if (int'(cmd_len) == 4)  w_burst = 3'b011;
    else if (int'(cmd_len) == 8)  w_burst = 3'b101;
    else if (int'(cmd_len) == 16) w_burst = 3'b111;
  end

  // State register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (cmd_valid) w_next = S_ADDR;
      S_ADDR: begin
        if (w_abort)                                  w_next = S_ABORT;
        else if (w_accept && r_left == LEN_W'(1))     w_next = S_LAST;
      end
      S_LAST: begin
        if (w_abort)     w_next = S_ABORT;
        else if (HREADY) w_next = S_IDLE;
      end
      S_ABORT: if (HREADY) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Bus transfer type and command/read-side status outputs.
  always_comb begin
    w_htrans    = T_IDLE;
    cmd_ready   = 1'b0;
    rdata_valid = 1'b0;
    rdata_last  = 1'b0;
    done        = 1'b0;
    unique case (r_state)
      S_IDLE: cmd_ready = 1'b1;
      S_ADDR: begin
        if (w_abort)      w_htrans = T_IDLE;
        else if (w_issue) w_htrans = r_first ? T_NONSEQ : T_SEQ;
        else              w_htrans = r_first ? T_IDLE : T_BUSY;
        rdata_valid = !r_write && r_dphase && HREADY && !(ABORT_EN && w_resp_err);
      end
      S_LAST: begin
        rdata_valid = !r_write && r_dphase && HREADY && !(ABORT_EN && w_resp_err);
        rdata_last  = rdata_valid;
        done        = HREADY;
      end
      S_ABORT: done = HREADY;
      default: w_htrans = T_IDLE;
    endcase
    err = done && (r_err || w_resp_err);
  end

  // Command capture, address advance, write-data register and error flag.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_addr   <= '0;
      r_wdata  <= '0;
      r_size   <= SIZE_MAX;
      r_burst  <= 3'b000;
      r_write  <= 1'b0;
      r_left   <= '0;
      r_first  <= 1'b0;
      r_dphase <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_capture) begin
        r_addr  <= cmd_addr;
        r_size  <= cmd_size;
        r_burst <= w_burst;
        r_write <= cmd_write;
        r_left  <= cmd_len;
        r_first <= 1'b1;
        r_err   <= 1'b0;
      end else if (w_accept) begin
        r_addr  <= r_addr + w_step;
        r_left  <= r_left - LEN_W'(1);
        r_first <= 1'b0;
      end
      if (wdata_ready)              r_wdata  <= wdata;
      if (HREADY)                   r_dphase <= w_accept;
      if (r_dphase && w_resp_err)   r_err    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ahb_burst_master.sv
// tb_ahb_burst_master: directed commands against a scripted AHB slave; the
// expected bus/stream activity is queued at issue time and a monitor pops it.
module tb_ahb_burst_master;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic        cmd_write = 1'b0;
  logic [2:0]  cmd_size = 3'd2;
  logic [4:0]  cmd_len = 5'd1;
  logic [31:0] wdata = '0;
  logic        wdata_valid = 1'b0;
  logic        wdata_ready;
  logic [31:0] rdata;
  logic        rdata_valid, rdata_last, done, err;
  logic [31:0] HADDR, HWDATA;
  logic [2:0]  HSIZE, HBURST;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic        HREADY = 1'b1;
  logic [31:0] HRDATA = '0;
  logic [1:0]  HRESP = 2'b00;

  ahb_burst_master #(.ADDR_W(32), .DATA_W(32), .LEN_W(5)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_size(cmd_size), .cmd_len(cmd_len),
    .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .rdata(rdata), .rdata_valid(rdata_valid), .rdata_last(rdata_last),
    .done(done), .err(err),
    .HADDR(HADDR), .HWDATA(HWDATA), .HSIZE(HSIZE), .HBURST(HBURST),
    .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
  );

  initial forever #5 HCLK = ~HCLK;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic [2:0]  burst;
    logic        write;
    logic [2:0]  size;
  } aph_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic        err;
  } dn_t;

  aph_t        q_aph[$];
  logic [31:0] q_busy[$];
  logic [32:0] q_rd[$];
  logic [31:0] q_wd[$];
  dn_t         q_dn[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int exp_done = 0;

  // slave script: wait states on one beat, two-cycle ERROR on one beat
  int g_wait_beat = -1;
  int g_wait_n = 0;
  int g_err_beat = -1;
  logic        dp_act = 1'b0;
  logic        dp_wr = 1'b0;
  logic [31:0] dp_addr = '0;
  int dp_wleft = 0;
  int dp_errph = 0;
  int beat = 0;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic miss(input string name, input string want);
    total++;
    bad++;
    $display("FAIL %s: got nothing/extra, want %s", name, want);
  endtask

  initial forever begin
    @(posedge HCLK);
    cyc = cyc + 1;
  end

  // Slave model and scoreboard monitor
  initial begin : mon
    aph_t        ea;
    dn_t         ed;
    logic [32:0] er;
    logic [31:0] ew;
    forever begin
      @(negedge HCLK);
      if (dp_act) begin
        HRDATA = pat(dp_addr);
        if (dp_errph == 2) begin
          HREADY = 1'b0; HRESP = 2'b01; dp_errph = 1;
        end else if (dp_errph == 1) begin
          HREADY = 1'b1; HRESP = 2'b01; dp_errph = 0;
        end else if (dp_wleft > 0) begin
          HREADY = 1'b0; HRESP = 2'b00; dp_wleft--;
        end else begin
          HREADY = 1'b1; HRESP = 2'b00;
        end
      end else begin
        HREADY = 1'b1; HRESP = 2'b00; HRDATA = '0;
      end
      #1;
      if (HRESETn) begin
        if (HTRANS[1]) begin
          if (HREADY) begin
            if (q_aph.size() == 0) miss("addr_phase_extra", "no transfer");
            else begin
              ea = q_aph.pop_front();
              chk("haddr",  64'(HADDR),  64'(ea.addr));
              chk("htrans", 64'(HTRANS), 64'(ea.trans));
              chk("hburst", 64'(HBURST), 64'(ea.burst));
              chk("hwrite", 64'(HWRITE), 64'(ea.write));
              chk("hsize",  64'(HSIZE),  64'(ea.size));
            end
          end else if (q_aph.size() != 0) begin
            chk("haddr_hold",  64'(HADDR),  64'(q_aph[0].addr));
            chk("htrans_hold", 64'(HTRANS), 64'(q_aph[0].trans));
          end
        end
        if (HTRANS == 2'b01) begin
          if (q_busy.size() == 0) miss("busy_extra", "no BUSY");
          else begin
            ew = q_busy.pop_front();
            chk("busy_haddr", 64'(HADDR), 64'(ew));
          end
        end
        if (rdata_valid) begin
          if (q_rd.size() == 0) miss("rdata_extra", "no rdata_valid");
          else begin
            er = q_rd.pop_front();
            chk("rdata_last_data", 64'({rdata_last, rdata}), 64'(er));
          end
        end
        if (dp_act && dp_wr && HREADY) begin
          if (q_wd.size() == 0) miss("hwdata_extra", "no write data phase");
          else begin
            ew = q_wd.pop_front();
            chk("hwdata", 64'(HWDATA), 64'(ew));
          end
        end
        if (done) begin
          done_cnt++;
          if (q_dn.size() == 0) miss("done_extra", "no done");
          else begin
            ed = q_dn.pop_front();
            chk("done_cycle", 64'(cyc), 64'(ed.cyc));
            chk("err",        64'(err), 64'(ed.err));
          end
        end
        if (HREADY) begin
          dp_act = HTRANS[1];
          if (HTRANS[1]) begin
            if (HTRANS == 2'b10) beat = 0;
            else beat = beat + 1;
            dp_addr  = HADDR;
            dp_wr    = HWRITE;
            dp_wleft = (beat == g_wait_beat) ? g_wait_n : 0;
            dp_errph = (beat == g_err_beat) ? 2 : 0;
          end
        end
      end else begin
        dp_act = 1'b0; dp_wleft = 0; dp_errph = 0;
      end
    end
  end

  task automatic push_aph(input logic [31:0] a, input logic [1:0] t, input logic [2:0] b,
                          input logic w, input logic [2:0] s);
    aph_t e;
    e.addr = a; e.trans = t; e.burst = b; e.write = w; e.size = s;
    q_aph.push_back(e);
  endtask

  task automatic flush();
    q_aph.delete(); q_busy.delete(); q_rd.delete(); q_wd.delete(); q_dn.delete();
  endtask

  task automatic issue(input logic [31:0] a, input logic wr, input logic [2:0] s,
                       input logic [4:0] len, output int c);
    int n;
    n = 0;
    @(negedge HCLK);
    while (!cmd_ready && n < 100) begin
      @(negedge HCLK);
      n++;
    end
    if (!cmd_ready) miss("cmd_ready_timeout", "cmd_ready=1");
    cmd_valid = 1'b1; cmd_addr = a; cmd_write = wr; cmd_size = s; cmd_len = len;
    c = cyc;
    @(negedge HCLK);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_cnt < exp_done && n < 300) begin
      @(negedge HCLK);
      n++;
    end
    if (done_cnt < exp_done) begin
      miss("done_timeout", "done pulse");
      exp_done = done_cnt;
      flush();
    end
    chk("queues_drained",
        64'(q_aph.size() + q_busy.size() + q_rd.size() + q_wd.size() + q_dn.size()), 64'(0));
  endtask

  task automatic run_read(input logic [31:0] a, input logic [2:0] s, input int len,
                          input logic [2:0] b, input int n_addr, input int n_rd,
                          input int done_off, input logic err_exp);
    logic [31:0] step;
    int c;
    dn_t d;
    step = 32'd1 << s;
    for (int i = 0; i < n_addr; i++)
      push_aph(a + 32'(i) * step, (i == 0) ? 2'b10 : 2'b11, b, 1'b0, s);
    for (int i = 0; i < n_rd; i++)
      q_rd.push_back({(i == len - 1), pat(a + 32'(i) * step)});
    issue(a, 1'b0, s, 5'(len), c);
    d.cyc = 32'(c + done_off); d.err = err_exp;
    q_dn.push_back(d);
    exp_done++;
    wait_done();
  endtask

  initial begin : stim
    logic [31:0] wd [3];
    int c, idx, gap, n;
    dn_t d;
    wd[0] = 32'hA000_0001; wd[1] = 32'hB000_0002; wd[2] = 32'hC000_0003;

    // reset then idle
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
    #1;
    chk("rst_haddr",  64'(HADDR),  64'(0));
    chk("rst_hwdata", 64'(HWDATA), 64'(0));
    chk("rst_hsize",  64'(HSIZE),  64'(2));
    chk("rst_hburst", 64'(HBURST), 64'(0));
    chk("rst_htrans", 64'(HTRANS), 64'(0));
    chk("rst_hwrite", 64'(HWRITE), 64'(0));
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("rst_flags", 64'({wdata_ready, rdata_valid, rdata_last, done, err}), 64'(0));

    // INCR4 read, zero wait: done at N+5
    run_read(32'h1000, 3'd2, 4, 3'b011, 4, 4, 5, 1'b0);

    // INCR (len 3) write with a 2-cycle wdata gap after beat 1
    push_aph(32'h2000, 2'b10, 3'b001, 1'b1, 3'd2);
    push_aph(32'h2004, 2'b11, 3'b001, 1'b1, 3'd2);
    push_aph(32'h2008, 2'b11, 3'b001, 1'b1, 3'd2);
    q_busy.push_back(32'h2004); q_busy.push_back(32'h2004);
    q_wd.push_back(wd[0]); q_wd.push_back(wd[1]); q_wd.push_back(wd[2]);
    wdata_valid = 1'b1; wdata = wd[0];
    issue(32'h2000, 1'b1, 3'd2, 5'd3, c);
    d.cyc = 32'(c + 6); d.err = 1'b0;
    q_dn.push_back(d);
    exp_done++;
    idx = 0; gap = 0; n = 0;
    while (idx < 3 && n < 50) begin
      #2;
      if (wdata_ready) begin
        idx++;
        if (idx == 1) gap = 2;
      end
      @(negedge HCLK);
      n++;
      if (gap > 0) begin
        wdata_valid = 1'b0; gap--;
      end else if (idx < 3) begin
        wdata_valid = 1'b1; wdata = wd[idx];
      end else wdata_valid = 1'b0;
    end
    wdata_valid = 1'b0;
    wait_done();

    // INCR8 read, 3 wait states on beat 2: done 3 cycles after N+9
    g_wait_beat = 1; g_wait_n = 3;
    run_read(32'h4000, 3'd2, 8, 3'b101, 8, 8, 12, 1'b0);
    g_wait_beat = -1; g_wait_n = 0;

    // ERROR on beat 2 of INCR4
    g_err_beat = 1;
`ifdef AHB_MASTER_ERR_ABORT_EN
    run_read(32'h5000, 3'd2, 4, 3'b011, 2, 1, 4, 1'b1);
`else
    run_read(32'h5000, 3'd2, 4, 3'b011, 4, 4, 6, 1'b1);
`endif
    g_err_beat = -1;

    // SINGLE read, then halfword INCR read
    run_read(32'h6004, 3'd2, 1, 3'b000, 1, 1, 2, 1'b0);
    run_read(32'h7002, 3'd1, 2, 3'b001, 2, 2, 3, 1'b0);

    // asynchronous reset in the middle of an INCR16
    for (int i = 0; i < 16; i++)
      push_aph(32'h8000 + 32'(i) * 32'd4, (i == 0) ? 2'b10 : 2'b11, 3'b111, 1'b0, 3'd2);
    for (int i = 0; i < 16; i++)
      q_rd.push_back({(i == 15), pat(32'h8000 + 32'(i) * 32'd4)});
    issue(32'h8000, 1'b0, 3'd2, 5'd16, c);
    repeat (4) @(negedge HCLK);
    HRESETn = 1'b0;
    #1;
    chk("arst_haddr",  64'(HADDR),  64'(0));
    chk("arst_hwdata", 64'(HWDATA), 64'(0));
    chk("arst_hsize",  64'(HSIZE),  64'(2));
    chk("arst_hburst", 64'(HBURST), 64'(0));
    chk("arst_htrans", 64'(HTRANS), 64'(0));
    chk("arst_hwrite", 64'(HWRITE), 64'(0));
    chk("arst_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("arst_flags", 64'({wdata_ready, rdata_valid, rdata_last, done, err}), 64'(0));
    flush();
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    run_read(32'h3000, 3'd2, 2, 3'b001, 2, 2, 3, 1'b0);

    repeat (3) @(negedge HCLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no end of test, want completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ahb_burst_master.md
# ahb_burst_master

Parametrised AHB-Lite bus master that turns a single command (address, direction, size, beat count) into a complete AHB transfer sequence. Supports SINGLE, INCR4/8/16 and undefined-length INCR bursts, wait states, write-data back-pressure via BUSY, and ERROR responses. It is the next generation of the team's fixed single/two-beat AHB master and sits between a local DMA/command engine and the AHB interconnect feeding the AHB-APB bridge.

## Interface
Parameters:
- ADDR_W, 32, HADDR width
- DATA_W, 32, HWDATA/HRDATA width; one of 32, 64
- LEN_W, 5, beat-count width; legal cmd_len 1..2^LEN_W-1

Ports:
- HCLK  in  1  AHB clock
- HRESETn  in  1  reset; asynchronous, active-low. Clock HCLK.
- cmd_valid / cmd_ready  in/out  1  command handshake
- cmd_addr  in  ADDR_W  start address, aligned to cmd_size
- cmd_write  in  1  1 = write
- cmd_size  in  3  HSIZE code, ≤ log2(DATA_W/8)
- cmd_len  in  LEN_W  beat count
- wdata / wdata_valid / wdata_ready  in/in/out  DATA_W/1/1  write-data stream
- rdata / rdata_valid / rdata_last  out  DATA_W/1/1  read-data stream, no back-pressure
- done  out  1  one-cycle pulse when the command completes
- err  out  1  valid with done; 1 = at least one ERROR response
- HADDR, HWDATA, HSIZE, HBURST, HTRANS, HWRITE  out  ADDR_W, DATA_W, 3, 3, 2, 1  AHB master outputs
- HREADY, HRDATA, HRESP  in  1, DATA_W, 2  AHB slave response; 00 OKAY, 01 ERROR, 10/11 are treated as ERROR

## Operation
- Reset values: HADDR=0, HWDATA=0, HSIZE=log2(DATA_W/8), HBURST=000, HTRANS=IDLE, HWRITE=0, cmd_ready=1, wdata_ready=0, rdata_valid=0, rdata_last=0, done=0, err=0.
- States: IDLE, ADDR (beats remaining in address phase), LAST (final data phase only), ABORT.
- IDLE: cmd_ready=1. A command is captured on cmd_valid&cmd_ready, and the state moves to ADDR.
- HBURST encoding: cmd_len 1→SINGLE 000; 4→INCR4 011; 8→INCR8 101; 16→INCR16 111; any other length→INCR 001.
- First beat is NONSEQ and later beats are SEQ. The address advances by 1<<cmd_size when a beat's address phase is accepted (HTRANS NONSEQ/SEQ and HREADY=1).
- Writes: a beat's address phase is issued only when wdata_valid=1. wdata_ready pulses on the cycle that beat is accepted. wdata is registered to HWDATA for the following data phase.
- If wdata_valid=0 mid-burst, the master drives BUSY and holds HADDR. If wdata_valid=0 before the first beat, HTRANS stays IDLE.
- Reads: rdata_valid=1 with rdata=HRDATA for each data phase that completes with HREADY=1. rdata_last marks the final beat.
- Once the last address phase is accepted, the state moves to LAST with HTRANS=IDLE. When the last data phase completes, done pulses, the state returns to IDLE, and cmd_ready goes to 1 on the next cycle.
- Staying inside a 1 KB boundary is the requester's responsibility and is not checked.

## Timing
- Command accepted at cycle N. HTRANS=NONSEQ at N+1 (reads, or writes with wdata_valid already high).
- Zero-wait-state burst of L beats: addresses at N+1..N+L, done at N+L+1.
- While HREADY=0, all address-phase outputs and HWDATA hold.
- ERROR (first cycle: HRESP=01 with HREADY=0):
  - With abort enabled, the master drives HTRANS=IDLE in that cycle.
  - Without abort, the pending address is held through the second cycle (HRESP=01, HREADY=1) and the burst resumes.
- An asynchronous reset mid-burst returns every output to its reset value immediately. The command is discarded.

## Configuration
- AHB_MASTER_ERR_ABORT_EN defined: an ERROR response terminates the burst. The remaining beats are not issued, and rdata_valid is not asserted for the errored beat. The master passes through ABORT (HTRANS=IDLE) for one cycle, then done=1 and err=1.
- Not defined: all beats complete. An errored read beat still asserts rdata_valid. A sticky error flag is reported as err=1 with done.

## Test plan
- Reset then idle: all outputs at reset values; cmd_ready=1.
- Read, cmd_addr=0x1000, len=4, size=010, zero wait: HBURST=011; HADDR 0x1000/04/08/0C with NONSEQ,SEQ,SEQ,SEQ; 4 rdata_valid pulses, last with rdata_last; done=1, err=0.
- Write, len=3, wdata_valid low for 2 cycles after beat 1: HBURST=001; BUSY for 2 cycles with HADDR held at 0x..04; HWDATA order preserved.
- Read, len=8, HREADY low 3 cycles on beat 2: outputs frozen; total 8 beats; done 3 cycles later than the zero-wait case.
- ERROR on beat 2 of INCR4: with the macro, HTRANS=IDLE and done/err=1, 1 rdata_valid. Without the macro, 4 beats complete and err=1.
- HRESETn asserted mid-INCR16: outputs reset asynchronously; the next command starts a fresh NONSEQ.
